// File: rtl/cache_pkg.sv
// Cache-side types shared by the memory arbiter and its users.
package cache_pkg;

  // Arbiter FSM: idle, icache owns the RAM, dcache owns the RAM.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IGNT = 2'd1,
    ARB_DGNT = 2'd2
  } arb_state_t;

  // Width of the icache starvation counter.
  localparam int unsigned STARVE_W = 3;

endpackage

// File: rtl/cpu_types_pkg.sv
// CPU-wide shared types: the RAM handshake status seen by the memory arbiter.
package cpu_types_pkg;

  // RAM status: ACCESS marks the cycle in which the requested word is done.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one RAM port between icache and dcache.
// dcache normally wins; after STARVE_MAX back-to-back dcache completions
// with icache waiting, icache is forced through once.
module mem_arbiter
  import cpu_types_pkg::*;
  import cache_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state_r;
  arb_state_t          next_state_s;
  logic [STARVE_W-1:0] starve_cnt_r;
  logic [STARVE_W-1:0] next_cnt_s;
  logic                d_req_s;
  logic                starve_full_s;
  logic                ren_s;
  logic                wen_s;
  logic [31:0]         addr_s;
  logic [31:0]         store_s;
  logic                iwait_s;
  logic                dwait_s;

  // Saturating increment of the starvation counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    if (v >= STARVE_LIM) begin
      return STARVE_LIM;
    end else begin
      return v + {{(STARVE_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign d_req_s       = dREN | dWEN;
  assign starve_full_s = (starve_cnt_r == STARVE_LIM);
  assign iload         = ramload;
  assign dload         = ramload;

  // State and starvation counter registers; reset wins over any transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ARB_IDLE;
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else begin
      state_r      <= next_state_s;
      starve_cnt_r <= next_cnt_s;
    end
  end

  // Next-state, counter update and raw RAM/wait drive for the current owner.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = starve_cnt_r;
    ren_s        = 1'b0;
    wen_s        = 1'b0;
    addr_s       = 32'h0000_0000;
    store_s      = 32'h0000_0000;
    iwait_s      = 1'b1;
    dwait_s      = 1'b1;
    case (state_r)
      ARB_IDLE: begin
        if (d_req_s && !(starve_full_s && iREN)) begin
          next_state_s = ARB_DGNT;
        end else if (iREN) begin
          next_state_s = ARB_IGNT;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_IGNT: begin
        ren_s  = iREN;
        addr_s = iaddr;
        // A dropped request abandons the grant without completing.
        if (!iREN) begin
          next_state_s = ARB_IDLE;
        end else if (ramstate == ACCESS) begin
          iwait_s      = 1'b0;
          next_state_s = ARB_IDLE;
          next_cnt_s   = {STARVE_W{1'b0}};
        end else begin
          next_state_s = ARB_IGNT;
        end
      end
      ARB_DGNT: begin
        // Write takes priority if both strobes are up.
        wen_s   = dWEN;
        ren_s   = dREN & ~dWEN;
        addr_s  = daddr;
        store_s = dstore;
        if (!d_req_s) begin
          next_state_s = ARB_IDLE;
        end else if (ramstate == ACCESS) begin
          dwait_s      = 1'b0;
          next_state_s = ARB_IDLE;
          if (iREN) begin
            next_cnt_s = sat_inc(starve_cnt_r);
          end else begin
            next_cnt_s = {STARVE_W{1'b0}};
          end
        end else begin
          next_state_s = ARB_DGNT;
        end
      end
      default: begin
        next_state_s = ARB_IDLE;
      end
    endcase
  end

  // Force idle-looking outputs while reset is held, even mid-grant.
  always_comb begin
    if (RST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'h0000_0000;
      ramstore = 32'h0000_0000;
      iwait    = 1'b1;
      dwait    = 1'b1;
    end else begin
      ramREN   = ren_s;
      ramWEN   = wen_s;
      ramaddr  = addr_s;
      ramstore = store_s;
      iwait    = iwait_s;
      dwait    = dwait_s;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive dcache grants allowed while icache waits.
REQ-002 SHALL have port CLK  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port iREN  in  1  icache read request.
REQ-005 SHALL have port iaddr  in  32  icache word address.
REQ-006 SHALL have port iload  out  32  icache read data.
REQ-007 SHALL have port iwait  out  1  icache stall; low only in the icache completion cycle.
REQ-008 SHALL have port dREN  in  1  dcache read request.
REQ-009 SHALL have port dWEN  in  1  dcache write request.
REQ-010 SHALL have port daddr  in  32  dcache word address.
REQ-011 SHALL have port dstore  in  32  dcache write data.
REQ-012 SHALL have port dload  out  32  dcache read data.
REQ-013 SHALL have port dwait  out  1  dcache stall; low only in the dcache completion cycle.
REQ-014 SHALL have ports ramREN, ramWEN  out  1 each  RAM strobes.
REQ-015 SHALL have ports ramaddr, ramstore  out  32 each; ramload  in  32; ramstate  in  ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-016 SHALL implement FSM states ARB_IDLE, ARB_IGNT, ARB_DGNT.
REQ-017 In ARB_IDLE, RAM strobes SHALL be 0, iwait=dwait=1; next state from pending requests.
REQ-018 Arbitration in ARB_IDLE: dcache request (dREN|dWEN) wins over iREN, unless starve count == STARVE_MAX and iREN is high, then icache wins.
REQ-019 No request in ARB_IDLE SHALL keep ARB_IDLE.
REQ-020 In ARB_IGNT, ramREN=iREN, ramWEN=0, ramaddr=iaddr, combinationally.
REQ-021 In ARB_DGNT, ramWEN=dWEN, ramREN=dREN&~dWEN (write priority), ramaddr=daddr, ramstore=dstore.
REQ-022 iload and dload SHALL both equal ramload at all times.
REQ-023 Completion: granted state and ramstate==ACCESS -> owner's wait=0 that cycle, FSM returns to ARB_IDLE next edge.
REQ-024 ramstate BUSY, FREE or ERROR in a grant state SHALL hold the state and keep the owner's wait=1 (ERROR retried).
REQ-025 Owner deasserting its request in a grant state SHALL return FSM to ARB_IDLE next edge with no completion signalled.
REQ-026 Non-owner wait SHALL stay 1 throughout another requester's grant.
REQ-027 Minimum latency: request seen in ARB_IDLE at cycle t, earliest completion t+1; back-to-back accesses from one requester cost one ARB_IDLE bubble each.
REQ-028 Starve counter (3-bit, saturating at STARVE_MAX): +1 on each dcache completion while iREN=1; cleared on any icache completion or on any dcache completion with iREN=0.
REQ-029 A 2-word dcache block transfer SHALL be two independent grants; icache may be granted between them only via REQ-018.

Reset
REQ-030 RST high at a clock edge SHALL force ARB_IDLE and starve count 0, overriding every other transition, including mid-grant.
REQ-031 Outputs during and after reset SHALL be ramREN=ramWEN=0, iwait=dwait=1, ramaddr=ramstore=0.

Structure
REQ-032 arb_state_t enum SHALL live in cache_pkg; ramstate_t stays in cpu_types_pkg.
REQ-033 SHALL be a single module with no sub-modules; one registered state, one registered counter, combinational output logic.

Verification
REQ-034 iREN=1, iaddr=0x100, ramstate ACCESS after 2 BUSY cycles -> iwait low exactly one cycle, iload=ramload, then ARB_IDLE.
REQ-035 iREN and dWEN raised same cycle, daddr=0x200, dstore=0xDEADBEEF -> dcache served first, ramWEN=1 with that addr/data, icache served next.
REQ-036 dREN held high for 5 accesses with iREN high, STARVE_MAX=4 -> icache granted after 4th dcache completion, counter back to 0.
REQ-037 ramstate=ERROR for 3 cycles during dcache read, then ACCESS -> dwait stays 1 through ERROR, low on ACCESS only.
REQ-038 RST asserted during ARB_DGNT with ramstate BUSY -> next cycle ARB_IDLE, strobes 0, both waits 1, counter 0.
REQ-039 dREN dropped mid-grant before ACCESS -> ARB_IDLE next edge, dwait never low, pending iREN granted afterwards.
